// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM. Sequences the shared datapath (one ALU,
// unified instruction/data memory, IR, A/B/ALUOut/MDR) one state per cycle,
// decodes the primary opcode itself and waits on the memory-ready handshake.
//
// state     | code | meaning
// ----------+------+-----------------------------------------------------
// FETCH     |  0   | read IR from mem[PC], PC <= PC+4 when memory is ready
// DECODE    |  1   | latch opcode, precompute branch target into ALUOut
// MEM_ADDR  |  2   | ALUOut <= A + sext(imm) for lw/sw
// MEM_READ  |  3   | read mem[ALUOut] into MDR, hold until ready
// MEM_WB    |  4   | rt <= MDR
// MEM_WRITE |  5   | mem[ALUOut] <= B, hold until ready
// EXEC_R    |  6   | ALUOut <= A funct B
// R_WB      |  7   | rd <= ALUOut
// EXEC_I    |  8   | ALUOut <= A op ext(imm)
// I_WB      |  9   | rt <= ALUOut
// BRANCH    |  10  | compare A/B, PC <= ALUOut if equal
// JUMP      |  11  | PC <= jump target, jal also writes $31 <= PC
// (12-15)   |  --  | unreachable, recover to FETCH
module multi_cycle_controller #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       rdy;

    // The branch decision is taken by the datapath through pc_write_cond,
    // so the zero flag does not steer the sequencing itself.
    logic unused_zero;
    assign unused_zero = zero;

    // With waiting disabled every memory access completes in one cycle.
    assign rdy = WAIT_EN ? mem_ready : 1'b1;

    // State and latched-opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state decode and Moore outputs; rst forces everything idle.
    always_comb begin
        state_d       = S_FETCH;
        op_d          = op_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_zero      = 1'b0;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                op_d      = op;
                case (op)
                    OP_RTYPE:                               state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                           state_d = S_MEM_ADDR;
                    OP_BEQ:                                 state_d = S_BRANCH;
                    OP_J, OP_JAL:                           state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_I_WB;
                case (op_q)
                    OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
                    OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                // PC already holds PC+4 here, which is the jal return address.
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            state_d       = S_FETCH;
            op_d          = op_q;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 2'b00;
            mem_to_reg    = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            ext_zero      = 1'b0;
            alu_op        = ALU_ADD;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
        end
    end

    // Debug view of the state; reads FETCH while reset is held.
    always_comb begin
        state = rst ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: one instance with memory waits
// enabled, one with them disabled, each checked cycle by cycle against a
// table of expected state codes and output bundles.
module tb_multi_cycle_controller;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] ER = 4'd6, RWB = 4'd7, EI = 4'd8, IWB = 4'd9, BR = 4'd10, JP = 4'd11;

    localparam logic [5:0] O_R = 6'h00, O_J = 6'h02, O_JAL = 6'h03, O_BEQ = 6'h04;
    localparam logic [5:0] O_ADDI = 6'h08, O_ANDI = 6'h0c, O_ORI = 6'h0d, O_XORI = 6'h0e, O_LUI = 6'h0f;
    localparam logic [5:0] O_LW = 6'h23, O_SW = 6'h2b;

    logic       clk = 1'b0;
    logic       rst_w, rst_nw;
    logic [5:0] op;
    logic       zero, mem_ready;

    logic       pcw_w, pcwc_w, iod_w, mr_w, mw_w, irw_w, rw_w, asa_w, ez_w, ill_w;
    logic [1:0] rd_w, mtr_w, asb_w, ps_w;
    logic [2:0] ao_w;
    logic [3:0] state_w;

    logic       pcw_n, pcwc_n, iod_n, mr_n, mw_n, irw_n, rw_n, asa_n, ez_n, ill_n;
    logic [1:0] rd_n, mtr_n, asb_n, ps_n;
    logic [2:0] ao_n;
    logic [3:0] state_n;

    logic [20:0] outs_w, outs_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_cycle_controller #(.WAIT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst_w), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_w), .pc_write_cond(pcwc_w), .i_or_d(iod_w), .mem_read(mr_w),
        .mem_write(mw_w), .ir_write(irw_w), .reg_write(rw_w), .reg_dst(rd_w),
        .mem_to_reg(mtr_w), .alu_src_a(asa_w), .alu_src_b(asb_w), .ext_zero(ez_w),
        .alu_op(ao_w), .pc_source(ps_w), .illegal_op(ill_w), .state(state_w)
    );

    multi_cycle_controller #(.WAIT_EN(1'b0)) u_dut_nowait (
        .clk(clk), .rst(rst_nw), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_n), .pc_write_cond(pcwc_n), .i_or_d(iod_n), .mem_read(mr_n),
        .mem_write(mw_n), .ir_write(irw_n), .reg_write(rw_n), .reg_dst(rd_n),
        .mem_to_reg(mtr_n), .alu_src_a(asa_n), .alu_src_b(asb_n), .ext_zero(ez_n),
        .alu_op(ao_n), .pc_source(ps_n), .illegal_op(ill_n), .state(state_n)
    );

    assign outs_w = {pcw_w, pcwc_w, iod_w, mr_w, mw_w, irw_w, rw_w, rd_w, mtr_w,
                     asa_w, asb_w, ez_w, ao_w, ps_w, ill_w};
    assign outs_n = {pcw_n, pcwc_n, iod_n, mr_n, mw_n, irw_n, rw_n, rd_n, mtr_n,
                     asa_n, asb_n, ez_n, ao_n, ps_n, ill_n};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected output bundle for a state, written from the state/output table.
    function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] dop,
                                          input logic [5:0] iop, input logic rdy, input logic r);
        logic       pw, pwc, iod, mr, mw, irw, rw, asa, ez, ill;
        logic [1:0] rd, mtr, asb, ps;
        logic [2:0] ao;
        {pw, pwc, iod, mr, mw, irw, rw, asa, ez, ill} = '0;
        {rd, mtr, asb, ps} = '0;
        ao = 3'b000;
        if (!r) begin
            case (st)
                F:   begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
                D:   begin
                         asb = 2'b11;
                         ill = !(dop inside {O_R, O_J, O_JAL, O_BEQ, O_ADDI, O_ANDI,
                                             O_ORI, O_XORI, O_LUI, O_LW, O_SW});
                     end
                MA:  begin asa = 1; asb = 2'b10; end
                MR:  begin mr = 1; iod = 1; end
                MWB: begin rw = 1; mtr = 2'b01; end
                MW:  begin mw = 1; iod = 1; end
                ER:  begin asa = 1; ao = 3'b010; end
                RWB: begin rw = 1; rd = 2'b01; end
                EI:  begin
                         asa = 1; asb = 2'b10;
                         if (iop == O_ANDI) begin ao = 3'b011; ez = 1; end
                         if (iop == O_ORI)  begin ao = 3'b100; ez = 1; end
                         if (iop == O_XORI) begin ao = 3'b101; ez = 1; end
                         if (iop == O_LUI)  ao = 3'b110;
                     end
                IWB: rw = 1;
                BR:  begin asa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
                JP:  begin
                         pw = 1; ps = 2'b10;
                         if (iop == O_JAL) begin rw = 1; rd = 2'b10; mtr = 2'b10; end
                     end
                default: ;
            endcase
        end
        return {pw, pwc, iod, mr, mw, irw, rw, rd, mtr, asa, asb, ez, ao, ps, ill};
    endfunction

    // One clock cycle: drive inputs, check the selected instance mid-cycle.
    task automatic cyc(input bit nw, input logic [3:0] exp_st, input logic [5:0] op_i,
                       input logic [5:0] iop, input logic rdy_i, input logic rst_i,
                       input string tag);
        op        = op_i;
        mem_ready = rdy_i;
        zero      = 1'($urandom_range(0, 1));
        rst_w     = nw ? 1'b1 : rst_i;
        rst_nw    = nw ? rst_i : 1'b1;
        @(negedge clk);
        if (nw) begin
            check({tag, ".state"}, {28'd0, state_n}, {28'd0, exp_st});
            check({tag, ".outs"}, {11'd0, outs_n}, {11'd0, model(exp_st, op_i, iop, 1'b1, rst_i)});
        end else begin
            check({tag, ".state"}, {28'd0, state_w}, {28'd0, exp_st});
            check({tag, ".outs"}, {11'd0, outs_w}, {11'd0, model(exp_st, op_i, iop, rdy_i, rst_i)});
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] iops [5];

    initial begin
        rst_w = 1'b1; rst_nw = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        iops[0] = O_ANDI; iops[1] = O_LUI; iops[2] = O_ADDI; iops[3] = O_ORI; iops[4] = O_XORI;

        // reset, then fetch stalled for three cycles
        cyc(0, F, O_R, O_R, 1, 1, "rst0");
        cyc(0, F, O_R, O_R, 1, 1, "rst1");
        for (int i = 0; i < 3; i++) cyc(0, F, O_R, O_R, 0, 0, "fetch_stall");
        cyc(0, F, O_R, O_R, 1, 0, "fetch_go");

        // lw, no waits
        cyc(0, D,   O_LW, O_LW, 1, 0, "lw_dec");
        cyc(0, MA,  O_LW, O_LW, 1, 0, "lw_addr");
        cyc(0, MR,  O_LW, O_LW, 1, 0, "lw_read");
        cyc(0, MWB, O_LW, O_LW, 1, 0, "lw_wb");

        // sw with two wait cycles; op input changes after DECODE
        cyc(0, F,  O_SW, O_SW, 1, 0, "sw_fetch");
        cyc(0, D,  O_SW, O_SW, 1, 0, "sw_dec");
        cyc(0, MA, O_LW, O_SW, 1, 0, "sw_addr");
        cyc(0, MW, O_LW, O_SW, 0, 0, "sw_hold0");
        cyc(0, MW, O_LW, O_SW, 0, 0, "sw_hold1");
        cyc(0, MW, O_LW, O_SW, 1, 0, "sw_done");

        // beq, jal, j
        cyc(0, F,  O_BEQ, O_BEQ, 1, 0, "beq_fetch");
        cyc(0, D,  O_BEQ, O_BEQ, 1, 0, "beq_dec");
        cyc(0, BR, O_BEQ, O_BEQ, 1, 0, "beq_br");
        cyc(0, F,  O_JAL, O_JAL, 1, 0, "jal_fetch");
        cyc(0, D,  O_JAL, O_JAL, 1, 0, "jal_dec");
        cyc(0, JP, O_JAL, O_JAL, 1, 0, "jal_jump");
        cyc(0, F,  O_J, O_J, 1, 0, "j_fetch");
        cyc(0, D,  O_J, O_J, 1, 0, "j_dec");
        cyc(0, JP, O_J, O_J, 1, 0, "j_jump");

        // R-type
        cyc(0, F,   O_R, O_R, 1, 0, "r_fetch");
        cyc(0, D,   O_R, O_R, 1, 0, "r_dec");
        cyc(0, ER,  O_R, O_R, 1, 0, "r_exec");
        cyc(0, RWB, O_R, O_R, 1, 0, "r_wb");

        // I-type ALU ops
        for (int i = 0; i < 5; i++) begin
            cyc(0, F,   iops[i], iops[i], 1, 0, "i_fetch");
            cyc(0, D,   iops[i], iops[i], 1, 0, "i_dec");
            cyc(0, EI,  iops[i], iops[i], 1, 0, "i_exec");
            cyc(0, IWB, iops[i], iops[i], 1, 0, "i_wb");
        end

        // lw with a read wait
        cyc(0, F,   O_LW, O_LW, 1, 0, "lws_fetch");
        cyc(0, D,   O_LW, O_LW, 1, 0, "lws_dec");
        cyc(0, MA,  O_LW, O_LW, 1, 0, "lws_addr");
        cyc(0, MR,  O_LW, O_LW, 0, 0, "lws_hold");
        cyc(0, MR,  O_LW, O_LW, 1, 0, "lws_read");
        cyc(0, MWB, O_LW, O_LW, 1, 0, "lws_wb");

        // illegal opcodes
        cyc(0, F, 6'h3f, 6'h3f, 1, 0, "ill_fetch");
        cyc(0, D, 6'h3f, 6'h3f, 1, 0, "ill_dec");
        cyc(0, F, 6'h01, 6'h01, 1, 0, "ill2_fetch");
        cyc(0, D, 6'h01, 6'h01, 1, 0, "ill2_dec");

        // reset aborting a store in progress
        cyc(0, F,  O_SW, O_SW, 1, 0, "ab_fetch");
        cyc(0, D,  O_SW, O_SW, 1, 0, "ab_dec");
        cyc(0, MA, O_SW, O_SW, 1, 0, "ab_addr");
        cyc(0, MW, O_SW, O_SW, 0, 0, "ab_hold");
        cyc(0, F,  O_SW, O_SW, 1, 1, "ab_rst");
        cyc(0, F,  O_R, O_R, 1, 0, "ab_fetch2");
        cyc(0, D,  O_R, O_R, 1, 0, "ab_dec2");
        cyc(0, ER, O_R, O_R, 1, 0, "ab_exec2");

        // waits disabled: mem_ready low never stalls
        cyc(1, F,   O_LW, O_LW, 0, 1, "nw_rst");
        cyc(1, F,   O_LW, O_LW, 0, 0, "nw_fetch");
        cyc(1, D,   O_LW, O_LW, 0, 0, "nw_lw_dec");
        cyc(1, MA,  O_LW, O_LW, 0, 0, "nw_lw_addr");
        cyc(1, MR,  O_LW, O_LW, 0, 0, "nw_lw_read");
        cyc(1, MWB, O_LW, O_LW, 0, 0, "nw_lw_wb");
        cyc(1, F,   O_SW, O_SW, 0, 0, "nw_sw_fetch");
        cyc(1, D,   O_SW, O_SW, 0, 0, "nw_sw_dec");
        cyc(1, MA,  O_SW, O_SW, 0, 0, "nw_sw_addr");
        cyc(1, MW,  O_SW, O_SW, 0, 0, "nw_sw_write");
        cyc(1, F,   O_R, O_R, 0, 0, "nw_fetch2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Moore-style control FSM that sequences a shared multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, IR, A/B/ALUOut/MDR registers.
- Decodes the 6-bit primary opcode internally and drives every datapath strobe and mux select, one state per cycle.
- Supports R-type, addi, andi, ori, xori, lw, sw, beq, lui, j, jal.
- Waits on a memory-ready handshake and flags illegal opcodes.

Parameters:
- WAIT_EN, 1, when 1 the memory states hold until mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- op  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag, sampled in BRANCH.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero=1.
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- reg_write  output  1  register file write.
- reg_dst  output  2  write register: 00=rt, 01=rd, 10=$31.
- mem_to_reg  output  2  write data: 00=ALUOut, 01=MDR, 10=PC.
- alu_src_a  output  1  ALU A input: 0=PC, 1=A.
- alu_src_b  output  2  ALU B input: 00=B, 01=4, 10=ext(imm), 11=sext(imm)<<2.
- ext_zero  output  1  immediate extension: 1=zero-extend, 0=sign-extend.
- alu_op  output  3  ALU operation: 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 xor, 110 lui (imm<<16).
- pc_source  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported.
- state  output  4  current state code, for debug.

Behaviour:
- Single clock clk. Reset is synchronous, active-high, on rst.
- While rst=1:
  - next state = FETCH.
  - All strobes are forced 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op.
  - All selects are forced 0.
  - state output reads 0.
- After reset deasserts, the first cycle is FETCH.
- Reset asserted mid-instruction aborts the instruction. No register or memory write occurs in the rst cycle.
- State codes:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE.
  - 6 EXEC_R, 7 R_WB, 8 EXEC_I, 9 I_WB, 10 BRANCH, 11 JUMP.
  - Codes 12-15 are unreachable and transition to FETCH.
- Outputs are a function of state only, except the mem_ready gating listed below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precomputed into ALUOut).
  - Next state by op:
    - 000000 goes to EXEC_R.
    - 001000, 001100, 001101, 001110, 001111 go to EXEC_I.
    - 100011 and 101011 go to MEM_ADDR.
    - 000100 goes to BRANCH.
    - 000010 and 000011 go to JUMP.
    - Any other op: illegal_op=1 and next state is FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, ext_zero=0, alu_op=000.
  - Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, reg_dst=00, mem_to_reg=01.
  - Goes to FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to FETCH.
  - mem_write stays asserted during the hold.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=010.
  - Goes to R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=01, mem_to_reg=00.
  - Goes to FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op by opcode: addi 000, andi 011, ori 100, xori 101, lui 110.
  - ext_zero=1 for andi, ori, xori; 0 otherwise.
  - Goes to I_WB.
- I_WB:
  - Outputs: reg_write=1, reg_dst=00, mem_to_reg=00.
  - Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01.
  - Goes to FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - For jal also: reg_write=1, reg_dst=10, mem_to_reg=10. PC is still PC+4 in this cycle, so $31 gets the return address.
  - Goes to FETCH.
- op is latched into an internal register at the DECODE cycle. Later states use the latched value, so op changing after DECODE has no effect.
- Cycle counts with mem_ready always 1:
  - lw 5; R-type, I-type ALU and sw 4; beq, j, jal 3.
  - Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- WAIT_EN=0: the wait states never hold, and strobes gated by mem_ready behave as if mem_ready=1.

Test Plan:
- Reset and fetch stall: rst=1 for 2 cycles, then mem_ready=0 for 3 cycles, then 1 → state 0 for 4 cycles; ir_write=pc_write=1 only in the 4th FETCH cycle; then state=1.
- lw (op=100011), mem_ready=1 → state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=01 only in state 4; total 5 cycles.
- sw (op=101011), mem_ready low for 2 cycles in MEM_WRITE → sequence 0,1,2,5,5,5,0; mem_write=1 for 3 cycles; reg_write never 1.
- beq (op=000100) → sequence 0,1,10,0; pc_write_cond=1 with pc_source=01 in state 10. jal (op=000011) → sequence 0,1,11,0 with pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
- I-type ALU: andi (op=001100) gives alu_op=011 and ext_zero=1 in state 8; lui (op=001111) gives alu_op=110; both follow with state 9, reg_dst=00.
- Illegal and reset abort: op=111111 → illegal_op=1 for exactly one cycle in state 1, then state 0. rst=1 asserted while in MEM_WRITE → no mem_write in the rst cycle, state 0 on the next cycle.
